// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: shares one palette lookup port between two sprite
// fetchers and registers the colour toward the compositor with valid/ready.
module palette_lookup_arbiter #(
    parameter int                IDX_W      = 4,
    parameter int                SEL_W      = 2,
    parameter bit                RR_EN      = 1'b1,
    parameter logic [IDX_W-1:0]  TRANSP_IDX = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_index,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_index,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             req1_ready,
    output logic [IDX_W-1:0] pal_index,
    output logic [SEL_W-1:0] pal_sel,
    input  logic [3:0]       pal_red,
    input  logic [3:0]       pal_green,
    input  logic [3:0]       pal_blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [11:0]      out_rgb,
    output logic             out_transparent
);
    logic             slot_free, gnt0, gnt1, gnt;
    logic             rr_q, rr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             src_q, src_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             transp_q, transp_d;

    // rr_q set means requester 1 holds priority on the next contested cycle
    always_comb begin
        slot_free  = !valid_q || out_ready;
        gnt0       = !Reset && slot_free && req0_valid && !(req1_valid && RR_EN && rr_q);
        gnt1       = !Reset && slot_free && req1_valid && !gnt0;
        gnt        = gnt0 || gnt1;
        req0_ready = gnt0;
        req1_ready = gnt1;
        pal_index  = gnt1 ? req1_index : gnt0 ? req0_index : idx_q;
        pal_sel    = gnt1 ? req1_sel : gnt0 ? req0_sel : sel_q;
        idx_d      = pal_index;
        sel_d      = pal_sel;
        rr_d       = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_q;
        valid_d    = gnt ? 1'b1 : out_ready ? 1'b0 : valid_q;
        src_d      = gnt ? gnt1 : src_q;
        rgb_d      = gnt ? {pal_red, pal_green, pal_blue} : rgb_q;
        transp_d   = gnt ? (pal_index == TRANSP_IDX) : transp_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_q     <= 1'b0;
            idx_q    <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            src_q    <= 1'b0;
            rgb_q    <= '0;
            transp_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
            rgb_q    <= rgb_d;
            transp_q <= transp_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_src         = src_q;
    assign out_rgb         = rgb_q;
    assign out_transparent = transp_q;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb_palette_lookup_arbiter: drives a round-robin and a fixed-priority instance
// side by side and compares both against a transaction-level reference.
module tb_palette_lookup_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ordy;
    logic        v0 [2], v1 [2];
    logic [3:0]  i0 [2], i1 [2];
    logic [1:0]  s0 [2], s1 [2];
    logic        r0 [2], r1 [2];
    logic [3:0]  pidx [2];
    logic [1:0]  psel [2];
    logic [11:0] prgb [2];
    logic        ov [2], osrc [2], otr [2];
    logic [11:0] orgb [2];
    logic [11:0] rom [4][16];

    int total = 0, bad = 0;
    int mode;
    bit          mv [2], msrc [2], mtr [2];
    int          mlast [2], g [2];
    logic [3:0]  midx [2];
    logic [1:0]  msel [2];
    logic [11:0] mrgb [2];

    always #5 clk = ~clk;

    assign prgb[0] = rom[psel[0]][pidx[0]];
    assign prgb[1] = rom[psel[1]][pidx[1]];

    palette_lookup_arbiter #(.RR_EN(1'b1)) dut_rr (
        .Clk(clk), .Reset(rst),
        .req0_valid(v0[0]), .req0_index(i0[0]), .req0_sel(s0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_index(i1[0]), .req1_sel(s1[0]), .req1_ready(r1[0]),
        .pal_index(pidx[0]), .pal_sel(psel[0]),
        .pal_red(prgb[0][11:8]), .pal_green(prgb[0][7:4]), .pal_blue(prgb[0][3:0]),
        .out_valid(ov[0]), .out_ready(ordy), .out_src(osrc[0]), .out_rgb(orgb[0]),
        .out_transparent(otr[0]));

    palette_lookup_arbiter #(.RR_EN(1'b0)) dut_fp (
        .Clk(clk), .Reset(rst),
        .req0_valid(v0[1]), .req0_index(i0[1]), .req0_sel(s0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_index(i1[1]), .req1_sel(s1[1]), .req1_ready(r1[1]),
        .pal_index(pidx[1]), .pal_sel(psel[1]),
        .pal_red(prgb[1][11:8]), .pal_green(prgb[1][7:4]), .pal_blue(prgb[1][3:0]),
        .out_valid(ov[1]), .out_ready(ordy), .out_src(osrc[1]), .out_rgb(orgb[1]),
        .out_transparent(otr[1]));

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d obs=%0h exp=%0h t=%0t", tag, d, obs, exp, $time);
        end
    endtask

    // Who should win: the lone requester, else the one not served last (RR) or requester 0.
    function automatic int pick(bit a, bit b, int last, bit rr);
        if (!a && !b) return -1;
        if (a && !b) return 0;
        if (b && !a) return 1;
        return rr ? 1 - last : 0;
    endfunction

    task automatic set_req(input int k, input bit v, input logic [3:0] idx, input logic [1:0] sel);
        for (int d = 0; d < 2; d++) begin
            if (k == 0) begin v0[d] = v; i0[d] = idx; s0[d] = sel; end
            else begin v1[d] = v; i1[d] = idx; s1[d] = sel; end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 0; msrc[d] = 0; mtr[d] = 0; mrgb[d] = 0;
            mlast[d] = 1; midx[d] = 0; msel[d] = 0;
        end
    endtask

    // One clock: check grant/port before the edge, results after it, then move requesters.
    task automatic cyc();
        logic [3:0] gi;
        logic [1:0] gs;
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d] = (rst || (mv[d] && !ordy)) ? -1 : pick(v0[d], v1[d], mlast[d], d == 0);
            chk("req0_ready", d, r0[d], g[d] == 0);
            chk("req1_ready", d, r1[d], g[d] == 1);
            chk("pal_index", d, pidx[d], g[d] == 0 ? i0[d] : g[d] == 1 ? i1[d] : midx[d]);
            chk("pal_sel", d, psel[d], g[d] == 0 ? s0[d] : g[d] == 1 ? s1[d] : msel[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mv[d] = 0; msrc[d] = 0; mtr[d] = 0; mrgb[d] = 0;
                mlast[d] = 1; midx[d] = 0; msel[d] = 0;
            end else if (g[d] >= 0) begin
                gi = g[d] == 0 ? i0[d] : i1[d];
                gs = g[d] == 0 ? s0[d] : s1[d];
                mv[d] = 1; msrc[d] = g[d][0]; mrgb[d] = rom[gs][gi]; mtr[d] = (gi == 4'd0);
                mlast[d] = g[d]; midx[d] = gi; msel[d] = gs;
            end else if (ordy) mv[d] = 0;
            chk("out_valid", d, ov[d], mv[d]);
            chk("out_src", d, osrc[d], msrc[d]);
            chk("out_rgb", d, orgb[d], mrgb[d]);
            chk("out_transparent", d, otr[d], mtr[d]);
            if (g[d] == 0 || (mode == 2 && !v0[d])) begin
                v0[d] = (mode == 1) || (mode == 2 && $urandom_range(1) == 1);
                i0[d] = 4'($urandom); s0[d] = 2'($urandom);
            end
            if (g[d] == 1 || (mode == 2 && !v1[d])) begin
                v1[d] = (mode == 1) || (mode == 2 && $urandom_range(1) == 1);
                i1[d] = 4'($urandom); s1[d] = 2'($urandom);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 16; i++) rom[s][i] = 12'($urandom);
        for (int s = 0; s < 4; s++) rom[s][0] = 12'hF0F;
        rom[0][4] = 12'h952;
        mode = 0; ordy = 1; rst = 1;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        model_reset();
        @(negedge clk);
        cyc(); cyc();
        rst = 0;
        for (int n = 0; n < 10; n++) cyc();
        chk("idle_pal_index", 0, pidx[0], 4'd0);

        set_req(0, 1, 4'd4, 2'd0);
        cyc();
        chk("first_rgb", 0, orgb[0], 12'h952);
        chk("first_src", 0, osrc[0], 1'b0);
        cyc();

        mode = 1;
        set_req(0, 1, 4'($urandom), 2'($urandom));
        set_req(1, 1, 4'($urandom), 2'($urandom));
        for (int n = 0; n < 8; n++) cyc();

        ordy = 0;
        for (int n = 0; n < 3; n++) cyc();
        ordy = 1;
        cyc(); cyc();

        mode = 0;
        for (int n = 0; n < 4; n++) cyc();
        set_req(0, 0, 0, 0);
        set_req(1, 1, 4'd0, 2'($urandom));
        cyc();
        chk("transp_flag", 0, otr[0], 1'b1);
        chk("transp_rgb", 0, orgb[0], 12'hF0F);
        chk("transp_src", 0, osrc[0], 1'b1);
        cyc();

        set_req(0, 1, 4'($urandom), 2'($urandom));
        set_req(1, 1, 4'($urandom), 2'($urandom));
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        set_req(0, 1, 4'($urandom), 2'($urandom));
        set_req(1, 1, 4'($urandom), 2'($urandom));
        #1;
        chk("post_reset_r0", 0, r0[0], 1'b1);
        cyc();
        cyc();

        mode = 2;
        for (int n = 0; n < 500; n++) begin
            ordy = $urandom_range(3) != 0;
            rst = $urandom_range(63) == 0;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Shares one combinational sprite palette lookup port (4-bit index in, 4/4/4 RGB out) between two pixel requesters: player-1 and player-2 sprite fetch units.
- Arbitrates with round-robin or fixed priority, drives the palette index and palette-select lines, and registers the returned colour.
- Flags the transparency key and presents one result per cycle through a valid/ready output toward the frame compositor.

Parameters:
- IDX_W, 4, palette index width.
- SEL_W, 2, palette-select width; chooses which sprite palette ROM is muxed onto the shared port.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
- TRANSP_IDX, 0, index value treated as transparent (magenta key entry).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a pixel lookup pending.
- req0_index  in  IDX_W  requester 0 palette index.
- req0_sel  in  SEL_W  requester 0 palette select.
- req0_ready  out  1  requester 0 lookup accepted this cycle.
- req1_valid  in  1  requester 1 has a pixel lookup pending.
- req1_index  in  IDX_W  requester 1 palette index.
- req1_sel  in  SEL_W  requester 1 palette select.
- req1_ready  out  1  requester 1 lookup accepted this cycle.
- pal_index  out  IDX_W  index driven to the shared palette port.
- pal_sel  out  SEL_W  palette select driven to the shared palette mux.
- pal_red, pal_green, pal_blue  in  4 each  combinational palette response, same cycle as pal_index/pal_sel.
- out_valid  out  1  result register holds a valid colour.
- out_ready  in  1  consumer accepts the result this cycle.
- out_src  out  1  requester id of the result.
- out_rgb  out  12  {red,green,blue} of the result.
- out_transparent  out  1  result index equalled TRANSP_IDX.

Behaviour:
- Reset values: out_valid=0, out_src=0, out_rgb=0, out_transparent=0, req0_ready=0, req1_ready=0, pal_index=0, pal_sel=0. The round-robin pointer resets so requester 0 has priority next.
- Slot free: slot_free = !out_valid || out_ready, combinational.
- Grant rule: grant is issued only when slot_free=1.
  - Only one valid requester: it wins.
  - Both valid, RR_EN=1: the requester not granted most recently wins.
  - Both valid, RR_EN=0: requester 0 wins.
- Ready signals: reqN_ready = grantN, combinational, same cycle. At most one ready is high per cycle. A request is accepted on reqN_valid && reqN_ready.
- Palette port: pal_index/pal_sel mux the granted requester's fields. With no grant they hold the last granted values. No glitch requirement.
- Latency: accept in cycle N -> out_valid=1 in N+1, carrying the palette response sampled in cycle N, out_src, and out_transparent = (index==TRANSP_IDX).
- Throughput: one result per cycle while out_ready=1.
- Backpressure: out_valid && !out_ready -> no grant, both readies 0, and out_* hold stable. Requesters must hold valid/index/sel until accepted.
- Slot update: if out_ready=1 and there is no grant in the same cycle, out_valid clears next cycle.
- Pointer update: the round-robin pointer changes only on an actual grant; idle cycles do not rotate it.
- Transparency: the RGB value is still passed through unmodified (magenta 0xF0F for the key entry). Compositing decisions belong downstream.
- Reset mid-operation: any result in flight is discarded, out_valid=0 the next cycle, and the pointer returns to requester 0. Requesters must re-present.
- No combinational path from out_ready to out_* data. A path from out_ready to reqN_ready is permitted.

Test Plan:
- Reset release, no requests -> out_valid=0 and both readies 0 for 10 cycles; pal_index=0.
- req0 only, index 4, sel 0, palette returns 9/5/2, out_ready=1 -> req0_ready=1 in cycle N; cycle N+1 shows out_valid=1, out_src=0, out_rgb=12'h952, out_transparent=0.
- Both valid continuously, RR_EN=1, out_ready=1 -> grants alternate 0,1,0,1 for 8 cycles and out_src alternates. With RR_EN=0, requester 0 wins all 8 cycles and req1_ready stays 0.
- Result pending, out_ready=0 for 3 cycles with both requesting -> both readies 0 and out_rgb stable. On out_ready=1 the next grant goes to the requester not last served, and the new result appears one cycle later.
- req1 index 0, palette returns F/0/F -> out_transparent=1, out_rgb=12'hF0F, out_src=1.
- Reset asserted the cycle after an accept -> out_valid=0 next cycle. After release, with both requesting, requester 0 is granted first.
